// File: rtl/rv32_pkg.sv
// Shared rv32 definitions: datapath widths used by the control unit and memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_pkg;

  localparam int XLEN   = 32;        // address and data width
  localparam int MASK_W = XLEN / 8;  // byte-enable mask width

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [MASK_W-1:0] mask_t;

endpackage : rv32_pkg

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port memory between instruction fetch and data access.
// Latency: read valid 3 cycles after the request is seen in IDLE, write valid 2 cycles.
// Backpressure: holds o_mem_* stable while i_mem_ready is low; o_stall freezes the core.
//
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_if_req/i_if_addr               fetch read request (held until o_if_valid)
//   o_if_rdata/o_if_valid            fetched instruction, one-cycle completion pulse
//   i_dm_ren/i_dm_wen/i_dm_addr/
//   i_dm_wdata/i_dm_mask             data read/write request (held until o_dm_valid)
//   o_dm_rdata/o_dm_valid            load data, one-cycle completion pulse
//   o_mem_req/o_mem_wen/o_mem_addr/
//   o_mem_wdata/o_mem_mask           shared memory request
//   i_mem_ready/i_mem_rvalid/
//   i_mem_rdata                      memory accept, read-data valid, read data
//   o_stall                          freeze core PC and pipeline
module mem_arbiter
  import rv32_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [XLEN-1:0]   i_if_addr,
  output logic [XLEN-1:0]   o_if_rdata,
  output logic              o_if_valid,
  input  logic              i_dm_ren,
  input  logic              i_dm_wen,
  input  logic [XLEN-1:0]   i_dm_addr,
  input  logic [XLEN-1:0]   i_dm_wdata,
  input  logic [MASK_W-1:0] i_dm_mask,
  output logic [XLEN-1:0]   o_dm_rdata,
  output logic              o_dm_valid,
  output logic              o_mem_req,
  output logic              o_mem_wen,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [MASK_W-1:0] o_mem_mask,
  input  logic              i_mem_ready,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_stall
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            r_state;
  state_t            w_next;
  logic              r_owner_if;  // 1: fetch owns the transaction, 0: data
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [MASK_W-1:0] r_mask;
  logic              r_wen;
  logic [3:0]        r_starve;
  logic [XLEN-1:0]   r_if_rdata;
  logic [XLEN-1:0]   r_dm_rdata;

  logic w_dm_req;
  logic w_grant_if;
  logic w_grant_dm;

  // Data normally wins; fetch only overtakes once it has been passed over LIMIT times.
  assign w_dm_req   = i_dm_ren | i_dm_wen;
  assign w_grant_if = i_if_req & (~w_dm_req | (r_starve == LIMIT));
  assign w_grant_dm = w_dm_req & ~w_grant_if;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant_if | w_grant_dm) w_next = S_ISSUE;
      S_ISSUE: if (i_mem_ready) w_next = r_wen ? S_RESP : S_WAIT;
      S_WAIT:  if (i_mem_rvalid) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner_if <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mask     <= '0;
      r_wen      <= 1'b0;
      r_starve   <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_grant_if) begin
          r_owner_if <= 1'b1;
          r_addr     <= i_if_addr;
          r_wdata    <= '0;
          r_mask     <= '1;
          r_wen      <= 1'b0;
          r_starve   <= '0;
        end else if (w_grant_dm) begin
          r_owner_if <= 1'b0;
          r_addr     <= i_dm_addr;
          r_wdata    <= i_dm_wdata;
          r_mask     <= i_dm_mask;
          r_wen      <= i_dm_wen;  // ren and wen together is a write
          if (!i_if_req)          r_starve <= '0;
          else if (r_starve < LIMIT) r_starve <= r_starve + 4'd1;
        end
      end
      // rvalid is only honoured in WAIT, which is entered strictly after accept.
      if (r_state == S_WAIT && i_mem_rvalid) begin
        if (r_owner_if) r_if_rdata <= i_mem_rdata;
        else            r_dm_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_mem_req   = (r_state == S_ISSUE);
  assign o_mem_wen   = r_wen;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_mask  = r_mask;

  assign o_if_valid  = (r_state == S_RESP) &  r_owner_if;
  assign o_dm_valid  = (r_state == S_RESP) & ~r_owner_if;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;

  assign o_stall = (i_if_req & ~o_if_valid) | (w_dm_req & ~o_dm_valid);

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_valid;
  logic        i_dm_ren, i_dm_wen;
  logic [31:0] i_dm_addr, i_dm_wdata;
  logic [3:0]  i_dm_mask;
  logic [31:0] o_dm_rdata;
  logic        o_dm_valid;
  logic        o_mem_req, o_mem_wen;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready, i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_stall;

  int n_pass = 0;
  int n_tot  = 0;

  logic [31:0] exp_if_rdata;
  logic [31:0] exp_dm_rdata;

  always #5 i_clk = ~i_clk;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_rdata(o_if_rdata), .o_if_valid(o_if_valid),
    .i_dm_ren(i_dm_ren), .i_dm_wen(i_dm_wen), .i_dm_addr(i_dm_addr),
    .i_dm_wdata(i_dm_wdata), .i_dm_mask(i_dm_mask),
    .o_dm_rdata(o_dm_rdata), .o_dm_valid(o_dm_valid),
    .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_stall(o_stall)
  );

  typedef struct {
    logic        if_req;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] mem_rdata;
    logic        exp_wen;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drop_reqs();
    i_if_req = 1'b0; i_dm_ren = 1'b0; i_dm_wen = 1'b0;
  endtask

  // One isolated transaction from IDLE, responding at minimum latency.
  task automatic run_vec(input vec_t v, input int idx);
    i_if_req   = v.if_req;
    i_dm_ren   = v.ren;
    i_dm_wen   = v.wen;
    i_if_addr  = v.if_req ? v.addr : 32'h0;
    i_dm_addr  = v.if_req ? 32'h0 : v.addr;
    i_dm_wdata = v.wdata;
    i_dm_mask  = v.mask;
    tick();  // cycle 1: ISSUE
    chk($sformatf("v%0d_req", idx), {31'b0, o_mem_req}, 32'd1);
    chk($sformatf("v%0d_addr", idx), o_mem_addr, v.addr);
    chk($sformatf("v%0d_wen", idx), {31'b0, o_mem_wen}, {31'b0, v.exp_wen});
    if (v.exp_wen) chk($sformatf("v%0d_wdata", idx), o_mem_wdata, v.wdata);
    if (!v.if_req) chk($sformatf("v%0d_mask", idx), {28'b0, o_mem_mask}, {28'b0, v.mask});
    i_mem_ready = 1'b1;
    tick();  // cycle 2
    i_mem_ready = 1'b0;
    if (v.exp_wen) begin
      chk($sformatf("v%0d_dm_valid", idx), {31'b0, o_dm_valid}, 32'd1);
      chk($sformatf("v%0d_dm_rdata_kept", idx), o_dm_rdata, exp_dm_rdata);
    end else begin
      chk($sformatf("v%0d_wait_noreq", idx), {31'b0, o_mem_req}, 32'd0);
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = v.mem_rdata;
      tick();  // cycle 3: RESP
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = 32'h0;
      if (v.if_req) begin
        exp_if_rdata = v.mem_rdata;
        chk($sformatf("v%0d_if_valid", idx), {31'b0, o_if_valid}, 32'd1);
        chk($sformatf("v%0d_if_rdata", idx), o_if_rdata, exp_if_rdata);
      end else begin
        exp_dm_rdata = v.mem_rdata;
        chk($sformatf("v%0d_dm_valid", idx), {31'b0, o_dm_valid}, 32'd1);
        chk($sformatf("v%0d_dm_rdata", idx), o_dm_rdata, exp_dm_rdata);
      end
    end
    drop_reqs();
    tick();  // back in IDLE
    chk($sformatf("v%0d_valids_clear", idx), {30'b0, o_if_valid, o_dm_valid}, 32'd0);
  endtask

  // Waits (bounded) for a memory request, serves it, returns the address seen.
  task automatic serve_one(output logic [31:0] addr);
    addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      if (o_mem_req) begin
        addr = o_mem_addr;
        break;
      end
      tick();
    end
    if (addr != 32'hFFFF_FFFF) begin
      i_mem_ready = 1'b1;
      tick();
      i_mem_ready = 1'b0;
      if (!o_mem_wen) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = addr ^ 32'h5A5A_0000;
        tick();
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'h0;
      end
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] starve_exp [10];

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,          4'h0, 32'h0050_0093, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0,          4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_2004, 32'h1234_5678,  4'h3, 32'h0,         1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_2008, 32'hCAFE_F00D,  4'hC, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_200C, 32'h0,          4'h1, 32'h0000_00A5, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0,          4'h0, 32'h0000_0013, 1'b0};

    i_rst = 1'b1;
    drop_reqs();
    i_if_addr = 32'h0; i_dm_addr = 32'h0; i_dm_wdata = 32'h0; i_dm_mask = 4'h0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
    exp_if_rdata = 32'h0;
    exp_dm_rdata = 32'h0;
    tick(); tick();
    i_rst = 1'b0;

    chk("rst_mem_req", {31'b0, o_mem_req}, 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_valids", {30'b0, o_if_valid, o_dm_valid}, 32'd0);
    chk("rst_if_rdata", o_if_rdata, 32'h0);
    chk("rst_dm_rdata", o_dm_rdata, 32'h0);
    chk("rst_stall", {31'b0, o_stall}, 32'd0);

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Simultaneous fetch and data write: data first, fetch arbitrated at cycle 3.
    i_if_req = 1'b1; i_if_addr = 32'h0000_0300;
    i_dm_wen = 1'b1; i_dm_addr = 32'h0000_0400; i_dm_wdata = 32'hA5A5_5A5A; i_dm_mask = 4'hF;
    tick();
    chk("sim_addr", o_mem_addr, 32'h0000_0400);
    chk("sim_wen", {31'b0, o_mem_wen}, 32'd1);
    chk("sim_mask", {28'b0, o_mem_mask}, 32'hF);
    chk("sim_stall", {31'b0, o_stall}, 32'd1);
    i_mem_ready = 1'b1;
    tick();
    i_mem_ready = 1'b0;
    chk("sim_dm_valid_c2", {31'b0, o_dm_valid}, 32'd1);
    i_dm_wen = 1'b0;
    tick();
    chk("sim_idle_c3", {31'b0, o_mem_req}, 32'd0);
    tick();
    chk("sim_fetch_req_c4", {31'b0, o_mem_req}, 32'd1);
    chk("sim_fetch_addr_c4", o_mem_addr, 32'h0000_0300);
    i_mem_ready = 1'b1;
    tick();
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1111_2222;
    tick();
    i_mem_rvalid = 1'b0;
    exp_if_rdata = 32'h1111_2222;
    chk("sim_if_valid", {31'b0, o_if_valid}, 32'd1);
    chk("sim_if_rdata", o_if_rdata, exp_if_rdata);
    drop_reqs();
    tick();

    // Starvation: fetch and data reads both held; LIMIT=4.
    for (int k = 0; k < 10; k++)
      starve_exp[k] = (k == 4 || k == 9) ? 32'h0000_0200 : 32'h0000_3000;
    i_if_req = 1'b1; i_if_addr = 32'h0000_0200;
    i_dm_ren = 1'b1; i_dm_addr = 32'h0000_3000; i_dm_mask = 4'hF;
    for (int k = 0; k < 10; k++) begin
      serve_one(got);
      chk($sformatf("starve_grant%0d", k), got, starve_exp[k]);
    end
    drop_reqs();
    tick(); tick();
    exp_dm_rdata = 32'h0000_3000 ^ 32'h5A5A_0000;
    chk("starve_dm_rdata", o_dm_rdata, exp_dm_rdata);

    // Backpressure: ready held low for 5 cycles.
    i_dm_ren = 1'b1; i_dm_addr = 32'h0000_0500; i_dm_mask = 4'hF;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_req%0d", k), {31'b0, o_mem_req}, 32'd1);
      chk($sformatf("bp_addr%0d", k), o_mem_addr, 32'h0000_0500);
      chk($sformatf("bp_stall%0d", k), {31'b0, o_stall}, 32'd1);
      tick();
    end
    i_mem_ready = 1'b1;
    tick();
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h7777_8888;
    tick();
    i_mem_rvalid = 1'b0;
    exp_dm_rdata = 32'h7777_8888;
    chk("bp_dm_valid", {31'b0, o_dm_valid}, 32'd1);
    chk("bp_dm_rdata", o_dm_rdata, exp_dm_rdata);
    drop_reqs();
    tick();

    // Reset while a fetch sits in WAIT; late rvalid/ready must be ignored.
    i_if_req = 1'b1; i_if_addr = 32'h0000_0600;
    tick();
    i_mem_ready = 1'b1;
    tick();
    i_mem_ready = 1'b0;
    chk("rw_in_wait", {31'b0, o_mem_req}, 32'd0);
    i_rst = 1'b1;
    drop_reqs();
    tick();
    i_rst = 1'b0;
    chk("rw_req_low", {31'b0, o_mem_req}, 32'd0);
    chk("rw_if_rdata", o_if_rdata, 32'h0);
    chk("rw_dm_rdata", o_dm_rdata, 32'h0);
    i_mem_rvalid = 1'b1; i_mem_ready = 1'b1; i_mem_rdata = 32'hFFFF_0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rw_no_valid%0d", k), {30'b0, o_if_valid, o_dm_valid}, 32'd0);
      chk($sformatf("rw_idle_req%0d", k), {31'b0, o_mem_req}, 32'd0);
    end
    i_mem_rvalid = 1'b0; i_mem_ready = 1'b0; i_mem_rdata = 32'h0;
    chk("rw_if_rdata_after", o_if_rdata, 32'h0);
    chk("rw_stall_idle", {31'b0, o_stall}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive data grants allowed while fetch waits; legal range is 1..15.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port i_if_req, input, 1 bit: instruction-fetch read request, held high until o_if_valid is seen.
REQ-005 SHALL have port i_if_addr, input, 32 bits: fetch address.
REQ-006 SHALL have port o_if_rdata, output, 32 bits: fetched instruction.
REQ-007 SHALL have port o_if_valid, output, 1 bit: one-cycle fetch completion pulse.
REQ-008 SHALL have ports i_dm_ren and i_dm_wen, input, 1 bit each: data read and data write requests, held until o_dm_valid is seen.
REQ-009 SHALL have ports i_dm_addr (32 bits), i_dm_wdata (32 bits) and i_dm_mask (4 bits), input: data address, write data and byte-enable mask.
REQ-010 SHALL have ports o_dm_rdata (32 bits) and o_dm_valid (1 bit), output: load data and the one-cycle data completion pulse.
REQ-011 SHALL have ports o_mem_req, o_mem_wen (1 bit each), o_mem_addr, o_mem_wdata (32 bits each) and o_mem_mask (4 bits), output: the shared single-port memory request.
REQ-012 SHALL have ports i_mem_ready, i_mem_rvalid (1 bit each) and i_mem_rdata (32 bits), input: memory accept, read-data valid and read data.
REQ-013 SHALL have port o_stall, output, 1 bit: freeze the core PC and pipeline.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP, with exactly one memory transaction outstanding at any time.
REQ-015 SHALL arbitrate only in IDLE: data wins over fetch unless fetch is pending and the starvation count equals STARVE_LIMIT, in which case fetch wins.
REQ-016 SHALL, on a grant in IDLE, register the owner, address, wdata, mask and wen, and go to ISSUE next cycle; with no request, the FSM stays in IDLE.
REQ-017 SHALL, when i_dm_ren and i_dm_wen are both high, treat the request as a write.
REQ-018 SHALL, in ISSUE, drive o_mem_req=1 with the registered fields held stable until i_mem_ready=1; a write then goes to RESP and a read goes to WAIT.
REQ-019 SHALL, in WAIT, capture i_mem_rdata into the owner's rdata register when i_mem_rvalid=1 and go to RESP; rvalid is honoured no earlier than the cycle after accept.
REQ-020 SHALL, in RESP, pulse the owner's valid for exactly one cycle, then return to IDLE; arbitration resumes the cycle after RESP.
REQ-021 SHALL hold o_if_rdata and o_dm_rdata until their next read completion; o_dm_rdata is unchanged by writes.
REQ-022 SHALL ignore i_mem_rvalid and i_mem_ready in IDLE and RESP, and ignore i_mem_rvalid in ISSUE.
REQ-023 SHALL not abort an in-flight transaction when the requester deasserts its request mid-transaction; the valid pulse still occurs.
REQ-024 SHALL, at each data grant with fetch pending, increment the starvation count, saturating at STARVE_LIMIT.
REQ-025 SHALL clear the starvation count on a fetch grant, or on a data grant with fetch not pending.
REQ-026 SHALL compute o_stall combinationally as (i_if_req & ~o_if_valid) | ((i_dm_ren | i_dm_wen) & ~o_dm_valid).
REQ-027 SHALL meet minimum latency, with request seen in IDLE at cycle 0: read valid at cycle 3 (ready at 1, rvalid at 2); write valid at cycle 2.
REQ-028 SHALL drive o_mem_req low in IDLE, WAIT and RESP.

Reset
REQ-029 SHALL, on i_rst=1 at a clock edge, set the state to IDLE, clear the starvation count, and zero all registered outputs including rdata, valids and o_mem_*.
REQ-030 SHALL, on reset mid-transaction, abandon the transaction: o_mem_req is low the next cycle, and late i_mem_rvalid or i_mem_ready is ignored with no valid pulse generated.

Structure
REQ-031 SHALL hold the state encodings as module-local constants; the memory mask width (4) and address/data width (32) SHALL come from the shared rv32 definitions package used by the control unit.
REQ-032 SHALL be a single module, with no sub-module.

Verification
REQ-033 SHALL cover fetch only: addr 0x100 with ready=1 at cycle 1 and rvalid at cycle 2 with rdata 0x00500093 gives o_if_valid at cycle 3 and o_if_rdata=0x00500093.
REQ-034 SHALL cover a simultaneous fetch and data write: data granted first, with o_mem_wen=1 and mask 0xF; o_dm_valid at cycle 2; fetch granted at cycle 3.
REQ-035 SHALL cover starvation: fetch held high with back-to-back data reads and STARVE_LIMIT=4 gives 4 data grants, then a fetch grant, then the count returns to 0.
REQ-036 SHALL cover backpressure: i_mem_ready low for 5 cycles keeps o_mem_req and o_mem_addr stable for 5 cycles, and o_stall=1 throughout.
REQ-037 SHALL cover reset in WAIT: i_rst pulse with later rvalid=1 gives no o_if_valid or o_dm_valid, the state returns to IDLE, and o_if_rdata=0.
REQ-038 SHALL cover ren and wen both high: a write is issued (o_mem_wen=1) and o_dm_rdata is unchanged.
